retrocomm_target_port: RTL

// Target-side endpoint of the RetroComm 16-bit DDR link; connects to the

---
 rtl/retrocomm_pkg.sv | 11 +
 rtl/rc_sync_fifo.sv | 51 +++++
 rtl/retrocomm_ddr_io.sv | 35 +++
 rtl/retrocomm_target_port.sv | 112 +++++++++++
 4 files changed

// File: rtl/retrocomm_pkg.sv
// Shared types for the RetroComm target port: 32-bit link words built from two 16-bit halves.
package retrocomm_pkg;

  typedef logic [31:0] rc_word_t;
  typedef logic [15:0] rc_half_t;

  function automatic rc_word_t rc_pack(input rc_half_t hi, input rc_half_t lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/rc_sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit for full/empty detection.
module rc_sync_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
               (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    do_pop   = pop_i & ~empty_o;
    // A pop on the same edge frees a slot, so a push into a full FIFO is still taken.
    do_push  = push_i & (~full_o | do_pop);
    wr_ptr_d = wr_ptr_q + {{AddrW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AddrW{1'b0}}, do_pop};
    data_o   = mem_q[rd_ptr_q[AddrW-1:0]];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/retrocomm_ddr_io.sv
// DDR pin logic: falling-edge capture of the high RX half and the clock-selected TX half mux.
module retrocomm_ddr_io
  import retrocomm_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        capture_i,
  input  logic [15:0] din_i,
  output logic [15:0] hi_o,
  input  logic [31:0] tx_word_i,
  output logic [15:0] dout_o
);

  rc_half_t hi_q, hi_d;

  always_comb begin
    hi_d = capture_i ? din_i : hi_q;
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q <= '0;
    end else begin
      hi_q <= hi_d;
    end
  end

  assign hi_o = hi_q;

  // Behavioural stand-in for a technology ODDR: low half in the high phase, high half in the low.
  always_comb begin
    dout_o = clk_i ? tx_word_i[15:0] : tx_word_i[31:16];
  end

endmodule

// File: rtl/retrocomm_target_port.sv
// RetroComm target endpoint: DDR RX deserialiser into an RX FIFO, TX FIFO drained onto Dout with
// a Raise marker, and a level Interrupt toward the initiator.
module retrocomm_target_port
  import retrocomm_pkg::*;
#(
  parameter int unsigned RX_DEPTH  = 16,
  parameter int unsigned TX_DEPTH  = 16,
  parameter bit          IRQ_ON_TX = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] Din,
  input  logic        Strobe,
  output logic [15:0] Dout,
  output logic        Raise,
  output logic        Interrupt,
  output logic [31:0] RxData,
  output logic        RxValid,
  input  logic        RxReady,
  input  logic [31:0] TxData,
  input  logic        TxValid,
  output logic        TxReady,
  input  logic        IrqReq,
  output logic        Overflow,
  input  logic        OvfClear
);

  rc_half_t rx_lo_q, rx_lo_d, rx_hi;
  logic     rx_armed_q, rx_armed_d;
  logic     rx_full, rx_empty, rx_drop;
  logic     ovf_q, ovf_d;
  logic     tx_full, tx_empty, tx_push;
  rc_word_t tx_head;
  rc_word_t out_q, out_d;
  logic     raise_q, raise_d;
  logic     irq_q, irq_d;

  always_comb begin
    rx_lo_d    = Strobe ? Din : rx_lo_q;
    rx_armed_d = Strobe;
    rx_drop    = rx_armed_q & rx_full & ~RxReady;
    ovf_d      = (ovf_q & ~OvfClear) | rx_drop;
    tx_push    = TxValid & ~tx_full;
    raise_d    = ~tx_empty;
    out_d      = tx_empty ? out_q : tx_head;
    // Set terms win over the initiator's Strobe acknowledge.
    irq_d      = IrqReq | (IRQ_ON_TX & tx_push & tx_empty) | (irq_q & ~Strobe);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rx_lo_q    <= '0;
      rx_armed_q <= 1'b0;
      ovf_q      <= 1'b0;
      out_q      <= '0;
      raise_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      rx_lo_q    <= rx_lo_d;
      rx_armed_q <= rx_armed_d;
      ovf_q      <= ovf_d;
      out_q      <= out_d;
      raise_q    <= raise_d;
      irq_q      <= irq_d;
    end
  end

  retrocomm_ddr_io u_ddr_io (
    .clk_i     (Clk),
    .rst_ni    (Reset_n),
    .capture_i (rx_armed_q),
    .din_i     (Din),
    .hi_o      (rx_hi),
    .tx_word_i (out_q),
    .dout_o    (Dout)
  );

  rc_sync_fifo #(
    .Depth (RX_DEPTH),
    .Width (32)
  ) u_rx_fifo (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .push_i  (rx_armed_q),
    .data_i  (rc_pack(rx_hi, rx_lo_q)),
    .pop_i   (RxReady),
    .data_o  (RxData),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  rc_sync_fifo #(
    .Depth (TX_DEPTH),
    .Width (32)
  ) u_tx_fifo (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .push_i  (tx_push),
    .data_i  (TxData),
    .pop_i   (1'b1),
    .data_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  assign RxValid   = ~rx_empty;
  assign TxReady   = ~tx_full;
  assign Raise     = raise_q;
  assign Interrupt = irq_q;
  assign Overflow  = ovf_q;

endmodule
